// File: rtl/ter_pkg.sv
// ----------------------------------------------------------------------------
// ter_pkg: shared constants and helpers for one-hot ternary logic cells.
//   Trit encoding (3 wires, one-hot): bit0 = -1, bit1 = 0, bit2 = +1.
//   TRIT_NONE (000) is the "no value" state used after reset and for
//   invalid inputs.
//   Mode encoding: STI/NTI/PTI inverter select; 2'b11 falls back to STI.
// ----------------------------------------------------------------------------
package ter_pkg;

    localparam logic [2:0] TRIT_NEG  = 3'b001;
    localparam logic [2:0] TRIT_ZERO = 3'b010;
    localparam logic [2:0] TRIT_POS  = 3'b100;
    localparam logic [2:0] TRIT_NONE = 3'b000;

    localparam logic [1:0] MODE_STI = 2'b00;
    localparam logic [1:0] MODE_NTI = 2'b01;
    localparam logic [1:0] MODE_PTI = 2'b10;

    // True when exactly one of the three wires is set.
    function automatic logic trit_valid(input logic [2:0] t);
        return (t == TRIT_NEG) || (t == TRIT_ZERO) || (t == TRIT_POS);
    endfunction

endpackage

// File: rtl/ter_inv_cell.sv
// ----------------------------------------------------------------------------
// ter_inv_cell: combinational per-trit ternary inverter decode.
//   trit_in  [2:0]  one-hot input trit
//   mode     [1:0]  STI / NTI / PTI select (11 -> STI)
//   trit_out [2:0]  one-hot inverted trit, 000 when input is invalid
//   invalid         input is not one-hot
// ----------------------------------------------------------------------------
module ter_inv_cell
    import ter_pkg::*;
(
    input  logic [2:0] trit_in,
    input  logic [1:0] mode,
    output logic [2:0] trit_out,
    output logic       invalid
);

    always_comb begin
        trit_out = TRIT_NONE;
        invalid  = !trit_valid(trit_in);
        if (!invalid) begin
            case (trit_in)
                TRIT_NEG: trit_out = TRIT_POS;
                TRIT_POS: trit_out = TRIT_NEG;
                // Only the middle value distinguishes the three inverters.
                TRIT_ZERO: begin
                    case (mode)
                        MODE_NTI: trit_out = TRIT_NEG;
                        MODE_PTI: trit_out = TRIT_POS;
                        default:  trit_out = TRIT_ZERO;
                    endcase
                end
                default: trit_out = TRIT_NONE;
            endcase
        end
    end

endmodule

// File: rtl/c_ter_inv.sv
// ----------------------------------------------------------------------------
// c_ter_inv: registered ternary inverter bank (STI/NTI/PTI per block).
//   clk                  rising-edge clock
//   rst                  synchronous active-high reset (outputs -> 0)
//   io_in  [3*NTRITS-1:0] one-hot trits, trit k at [3k+2:3k]
//   mode   [1:0]          00 STI, 01 NTI, 10 PTI, 11 STI
//   io_out [3*NTRITS-1:0] inverted trits, one cycle after io_in
//   err    [NTRITS-1:0]   per-trit invalid-input flag
// Optional macro TER_INV_STICKY_ERR_EN: err bits hold once set until rst.
// ----------------------------------------------------------------------------
module c_ter_inv
    import ter_pkg::*;
#(
    parameter int NTRITS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3*NTRITS-1:0]   io_in,
    input  logic [1:0]            mode,
    output logic [3*NTRITS-1:0]   io_out,
    output logic [NTRITS-1:0]     err
);

    logic [3*NTRITS-1:0] out_d;
    logic [NTRITS-1:0]   inv_d;

    for (genvar k = 0; k < NTRITS; k++) begin : g_cell
        ter_inv_cell u_cell (
            .trit_in  (io_in[3*k +: 3]),
            .mode     (mode),
            .trit_out (out_d[3*k +: 3]),
            .invalid  (inv_d[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_out <= '0;
            err    <= '0;
        end else begin
            io_out <= out_d;
`ifdef TER_INV_STICKY_ERR_EN
            err    <= err | inv_d;
`else
            err    <= inv_d;
`endif
        end
    end

endmodule

// File: tb/tb_c_ter_inv.sv
// ----------------------------------------------------------------------------
// tb_c_ter_inv: scoreboard bench for c_ter_inv with NTRITS=2.
//   Expected io_out/err are computed from an arithmetic ternary model when
//   stimulus is driven, queued, and compared after the next rising edge.
// ----------------------------------------------------------------------------
module tb_c_ter_inv;

    localparam int NT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [3*NT-1:0] io_in;
    logic [1:0]    mode;
    logic [3*NT-1:0] io_out;
    logic [NT-1:0] err;

    int checks = 0;
    int errors = 0;

    logic [3*NT-1:0] q_out[$];
    logic [NT-1:0]   q_err[$];
    logic [NT-1:0]   sticky_m = '0;

    c_ter_inv #(.NTRITS(NT)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_in  (io_in),
        .mode   (mode),
        .io_out (io_out),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    // Model: decode to -1/0/+1, apply inverter arithmetically, re-encode.
    // Returns {invalid, out[2:0]}.
    function automatic logic [3:0] model_trit(input logic [2:0] t, input logic [1:0] m);
        int v, r;
        case (t)
            3'b001: v = -1;
            3'b010: v = 0;
            3'b100: v = 1;
            default: return 4'b1000;
        endcase
        case (m)
            2'b01:   r = (v == -1) ? 1 : -1;
            2'b10:   r = (v == 1) ? -1 : 1;
            default: r = -v;
        endcase
        return {1'b0, (r == -1) ? 3'b001 : (r == 0) ? 3'b010 : 3'b100};
    endfunction

    // Compare the entry due this cycle, then drive new stimulus and queue
    // its expectation for the following edge.
    task automatic step(input logic r, input logic [1:0] m, input logic [3*NT-1:0] din, input string tag);
        logic [3*NT-1:0] eo;
        logic [NT-1:0]   ei, ee;
        logic [3:0]      res;
        @(negedge clk);
        if (q_out.size() > 0) begin
            chk({tag, ".out"}, 32'(io_out), 32'(q_out.pop_front()));
            chk({tag, ".err"}, 32'(err), 32'(q_err.pop_front()));
        end
        rst = r; mode = m; io_in = din;
        for (int k = 0; k < NT; k++) begin
            res = model_trit(din[3*k +: 3], m);
            eo[3*k +: 3] = res[2:0];
            ei[k] = res[3];
        end
        if (r) begin
            eo = '0; ei = '0; sticky_m = '0;
        end
        sticky_m = sticky_m | ei;
`ifdef TER_INV_STICKY_ERR_EN
        ee = sticky_m;
`else
        ee = ei;
`endif
        q_out.push_back(eo);
        q_err.push_back(ee);
    endtask

    initial begin
        logic [3*NT-1:0] rin;
        rst = 1'b1; mode = 2'b00; io_in = '0;
        // Reset held two cycles with valid input present.
        step(1, 2'b00, 6'b010_010, "rst0");
        step(1, 2'b00, 6'b010_010, "rst1");
        // First valid output one cycle after release.
        step(0, 2'b00, 6'b010_010, "rst_rel");
        // STI sweep on low trit (high trit kept valid).
        step(0, 2'b00, 6'b010_001, "sti_neg");
        step(0, 2'b00, 6'b010_100, "sti_pos");
        step(0, 2'b00, 6'b001_010, "sti_zero");
        // NTI/PTI/reserved mode.
        step(0, 2'b01, 6'b010_010, "nti_zero");
        step(0, 2'b01, 6'b100_001, "nti_mix");
        step(0, 2'b10, 6'b010_010, "pti_zero");
        step(0, 2'b10, 6'b100_001, "pti_mix");
        step(0, 2'b11, 6'b100_100, "mode11");
        step(0, 2'b11, 6'b010_010, "mode11_z");
        // Invalid low trit, then recovery (err clears or sticks by build).
        step(0, 2'b00, 6'b010_011, "inv_011");
        step(0, 2'b00, 6'b010_001, "recover");
        step(0, 2'b00, 6'b100_000, "inv_000");
        step(0, 2'b00, 6'b111_010, "inv_111");
        step(0, 2'b00, 6'b110_101, "inv_both");
        step(0, 2'b00, 6'b001_100, "valid_after");
        // Reset mid-stream clears outputs and sticky state.
        step(1, 2'b00, 6'b001_100, "rst_mid");
        step(0, 2'b00, 6'b001_100, "resume0");
        step(0, 2'b01, 6'b010_010, "resume1");
        // Random stretch.
        for (int i = 0; i < 40; i++) begin
            rin = 6'($urandom_range(0, 63));
            step(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)), rin, "rand");
        end
        step(0, 2'b00, 6'b010_010, "drain");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
